sd_spi_cmd_ctrl: RTL

- Sequences SD-card SPI-mode transactions over the quad-SPI-style bridge interface (spi_sck, spi_dq_o, spi_dq_i, spi_cs).
- Generates the power-up dummy clocks, frames 48-bit SD commands and polls for the R1 response with a timeout.
- Sits between a software-visible command register block and the SDIO/SPI pin bridge, replacing a generic SPI master for SD boot and bring-up.

---
 rtl/sd_spi_pkg.sv | 36 +++
 rtl/sd_spi_byte_shifter.sv | 81 ++++++++
 rtl/sd_spi_cmd_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/sd_spi_pkg.sv
// Shared types and SD SPI-mode framing constants for the SD command controller.
package sd_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    SEL,
    CMD,
    RESP,
    DESEL,
    DONE
  } state_t;

  localparam logic [1:0]  START_BITS  = 2'b01;
  localparam logic        STOP_BIT    = 1'b1;
  localparam logic [7:0]  IDLE_BYTE   = 8'hFF;
  localparam int unsigned R1_BUSY_BIT = 7;

  // Byte n (0..5) of the 48-bit command frame, MSB first.
  function automatic logic [7:0] cmd_frame_byte(input logic [5:0]  index,
                                                 input logic [31:0] arg,
                                                 input logic [6:0]  crc,
                                                 input logic [2:0]  n);
    logic [7:0] b;
    case (n)
      3'd0:    b = {START_BITS, index};
      3'd1:    b = arg[31:24];
      3'd2:    b = arg[23:16];
      3'd3:    b = arg[15:8];
      3'd4:    b = arg[7:0];
      default: b = {crc, STOP_BIT};
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sd_spi_byte_shifter.sv
// Mode-0 SPI byte engine: SCK divider, MSB-first TX/RX shift registers and
// a 2-flop MISO synchroniser. Shifts last_bit+1 bits per start.
module sd_spi_byte_shifter
  import sd_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic [2:0] last_bit,
  input  logic       miso,
  output logic       sck,
  output logic       mosi,
  output logic       done,
  output logic [7:0] rx_byte
);

  localparam int unsigned DW = $clog2(CLK_DIV);

  logic [DW-1:0] div_cnt;
  logic [2:0]    bit_cnt;
  logic [2:0]    last_q;
  logic [6:0]    tx_sr;
  logic [7:0]    rx_sr;
  logic          active;
  logic          miso_s1;
  logic          miso_s2;

  assign rx_byte = rx_sr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      last_q  <= '1;
      tx_sr   <= '1;
      rx_sr   <= '1;
      active  <= 1'b0;
      sck     <= 1'b0;
      mosi    <= 1'b1;
      done    <= 1'b0;
      miso_s1 <= 1'b1;
      miso_s2 <= 1'b1;
    end else begin
      miso_s1 <= miso;
      miso_s2 <= miso_s1;
      done    <= 1'b0;
      if (start && !active) begin
        active  <= 1'b1;
        tx_sr   <= tx_byte[6:0];
        mosi    <= tx_byte[7];
        div_cnt <= '0;
        bit_cnt <= '0;
        last_q  <= last_bit;
      end else if (active) begin
        if (div_cnt == DW'(CLK_DIV - 1)) begin
          div_cnt <= '0;
          sck     <= ~sck;
          if (sck) begin
            // Last clk of the high half: sample, then the falling edge shifts MOSI.
            rx_sr <= {rx_sr[6:0], miso_s2};
            if (bit_cnt == last_q) begin
              active <= 1'b0;
              done   <= 1'b1;
              mosi   <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              mosi    <= tx_sr[6];
              tx_sr   <= {tx_sr[5:0], 1'b1};
            end
          end
        end else begin
          div_cnt <= div_cnt + DW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/sd_spi_cmd_ctrl.sv
// SD-card SPI-mode command sequencer: power-up dummy clocks, 48-bit command
// framing and R1 polling with timeout, over the SDIO/SPI pin bridge.
module sd_spi_cmd_ctrl
  import sd_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned INIT_CLOCKS  = 80,
  parameter int unsigned RESP_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        init_req,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic [6:0]  cmd_crc,
  output logic        resp_valid,
  output logic [7:0]  resp_r1,
  output logic        resp_timeout,
  output logic        busy,
  output logic        spi_sck,
  output logic [3:0]  spi_dq_o,
  input  logic [3:0]  spi_dq_i,
  output logic        spi_cs
);

  localparam int unsigned PW = $clog2(RESP_TIMEOUT + 1);
  localparam int unsigned IW = $clog2(INIT_CLOCKS + 1);

  state_t        state, state_n;
  logic          ready_en;
  logic [2:0]    byte_cnt;
  logic [PW-1:0] poll_cnt;
  logic [IW-1:0] init_rem;
  logic [IW-1:0] init_src;
  logic [2:0]    init_last;
  logic [5:0]    idx_q;
  logic [31:0]   arg_q;
  logic [6:0]    crc_q;
  logic [7:0]    r1_pend;
  logic          to_pend;
  logic          poll_hit;
  logic          poll_last;

  logic          sh_start;
  logic [7:0]    sh_tx;
  logic [2:0]    sh_last;
  logic          sh_done;
  logic [7:0]    sh_rx;
  logic          sh_mosi;
  logic          unused_dq;

  assign unused_dq = ^{spi_dq_i[3:2], spi_dq_i[0]};

  sd_spi_byte_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (sh_start),
    .tx_byte  (sh_tx),
    .last_bit (sh_last),
    .miso     (spi_dq_i[1]),
    .sck      (spi_sck),
    .mosi     (sh_mosi),
    .done     (sh_done),
    .rx_byte  (sh_rx)
  );

  assign cmd_ready  = (state == IDLE) && ready_en;
  assign busy       = (state != IDLE);
  assign resp_valid = (state == DONE);
  assign spi_cs     = !((state == SEL) || (state == CMD) || (state == RESP));
  assign spi_dq_o   = {3'b000, sh_mosi};

  // The next byte is launched in the same cycle the previous one reports done,
  // so tx data is chosen for the state being entered, not the current one.
  always_comb begin
    state_n   = state;
    sh_start  = 1'b0;
    sh_tx     = IDLE_BYTE;
    sh_last   = 3'd7;
    init_src  = (state == IDLE) ? IW'(INIT_CLOCKS) : init_rem;
    init_last = (init_src >= IW'(8)) ? 3'd7 : 3'(init_src - IW'(1));
    poll_hit  = ~sh_rx[R1_BUSY_BIT];
    poll_last = (poll_cnt == PW'(RESP_TIMEOUT - 1));
    unique case (state)
      IDLE: begin
        if (ready_en) begin
          if (init_req) begin
            state_n  = INIT;
            sh_start = 1'b1;
            sh_last  = init_last;
          end else if (cmd_valid) begin
            state_n  = SEL;
            sh_start = 1'b1;
          end
        end
      end
      INIT: begin
        if (sh_done) begin
          if (init_rem == '0) begin
            state_n = IDLE;
          end else begin
            sh_start = 1'b1;
            sh_last  = init_last;
          end
        end
      end
      SEL: begin
        if (sh_done) begin
          state_n  = CMD;
          sh_start = 1'b1;
          sh_tx    = cmd_frame_byte(idx_q, arg_q, crc_q, 3'd0);
        end
      end
      CMD: begin
        if (sh_done) begin
          sh_start = 1'b1;
          if (byte_cnt == 3'd5) begin
            state_n = RESP;
          end else begin
            sh_tx = cmd_frame_byte(idx_q, arg_q, crc_q, byte_cnt + 3'd1);
          end
        end
      end
      RESP: begin
        if (sh_done) begin
          sh_start = 1'b1;
          if (poll_hit || poll_last) state_n = DESEL;
        end
      end
      DESEL: begin
        if (sh_done) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      ready_en     <= 1'b0;
      byte_cnt     <= '0;
      poll_cnt     <= '0;
      init_rem     <= '0;
      idx_q        <= '0;
      arg_q        <= '0;
      crc_q        <= '0;
      r1_pend      <= IDLE_BYTE;
      to_pend      <= 1'b0;
      resp_r1      <= IDLE_BYTE;
      resp_timeout <= 1'b0;
    end else begin
      state    <= state_n;
      ready_en <= 1'b1;
      if (sh_start && (state_n == INIT))
        init_rem <= init_src - (IW'(init_last) + IW'(1));
      if ((state == IDLE) && (state_n == SEL)) begin
        idx_q    <= cmd_index;
        arg_q    <= cmd_arg;
        crc_q    <= cmd_crc;
        byte_cnt <= '0;
        poll_cnt <= '0;
      end
      if ((state == CMD) && sh_done)
        byte_cnt <= byte_cnt + 3'd1;
      if ((state == RESP) && sh_done) begin
        if (poll_hit) begin
          r1_pend <= sh_rx;
          to_pend <= 1'b0;
        end else begin
          if (poll_cnt != PW'(RESP_TIMEOUT)) poll_cnt <= poll_cnt + PW'(1);
          if (poll_last) begin
            r1_pend <= IDLE_BYTE;
            to_pend <= 1'b1;
          end
        end
      end
      // Result registers only change entering DONE so they hold between completions.
      if ((state == DESEL) && sh_done) begin
        resp_r1      <= r1_pend;
        resp_timeout <= to_pend;
      end
    end
  end

endmodule
